// File: rtl/cirno_pkg.sv
// cirno_pkg: shared types and default sizes for the cirno register file.
// Defines the execute-port write opcode and a helper that classifies it.
package cirno_pkg;

    localparam int CIRNO_W     = 8;
    localparam int CIRNO_NREGS = 4;
    localparam int CIRNO_IMM_W = 6;

    // Execute-port write opcode; codes 5..7 are reserved and act as WR_NONE
    typedef enum logic [2:0] {
        WR_NONE   = 3'd0,
        WR_RESULT = 3'd1,
        WR_HI     = 3'd2,
        WR_LO     = 3'd3,
        WR_COPY   = 3'd4
    } wr_op_e;

    // Writes that never wait on the scoreboard
    function automatic logic is_plain_write(input wr_op_e op);
        return (op == WR_RESULT) || (op == WR_HI) || (op == WR_LO);
    endfunction

endpackage

// File: rtl/cirno_scoreboard.sv
// cirno_scoreboard: one pending bit per register for outstanding memory loads,
// plus the stall decode for operand reads and register copies.
// Optional macro CIRNO_REGFILE_BYPASS_EN: a memory writeback arriving in the
// same cycle as an operand read of its pending register releases that read.
module cirno_scoreboard
    import cirno_pkg::*;
#(
    parameter int NREGS = CIRNO_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ld_issue,
    input  logic [AW-1:0]    i_ld_addr,
    input  logic             i_mem_we,
    input  logic [AW-1:0]    i_mem_addr,
    input  logic             i_rd_en,
    input  logic             i_rx_en,
    input  logic             i_ry_en,
    input  logic [AW-1:0]    i_ra_x,
    input  logic [AW-1:0]    i_ra_y,
    input  logic             i_copy_req,
    input  logic [AW-1:0]    i_wr_src,
    output logic             o_stall,
    output logic [NREGS-1:0] o_pending
);

    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    logic             w_x_wait;
    logic             w_y_wait;
    logic             w_src_wait;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_decode
            assign w_set[gi] = i_ld_issue && (i_ld_addr == AW'(gi));
            assign w_clr[gi] = i_mem_we && (i_mem_addr == AW'(gi));
        end
    endgenerate

    // Pending bits: a newly issued load outranks a returning one on the same register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

`ifdef CIRNO_REGFILE_BYPASS_EN
    // Operand waits, released when the data is being written back this cycle
    always_comb begin
        w_x_wait = i_rx_en && r_pending[i_ra_x] && !(i_mem_we && (i_mem_addr == i_ra_x));
        w_y_wait = i_ry_en && r_pending[i_ra_y] && !(i_mem_we && (i_mem_addr == i_ra_y));
    end
`else
    // Operand waits on the registered scoreboard only
    always_comb begin
        w_x_wait = i_rx_en && r_pending[i_ra_x];
        w_y_wait = i_ry_en && r_pending[i_ra_y];
    end
`endif

    // Copy reads the stored array directly, so it always waits on its source
    assign w_src_wait = i_copy_req && r_pending[i_wr_src];

    assign o_stall   = (i_rd_en && (w_x_wait || w_y_wait)) || w_src_wait;
    assign o_pending = r_pending;

endmodule

// File: rtl/cirno_regfile.sv
// cirno_regfile: parametrised register file with registered X/Y operands,
// execute and memory write ports, half-word immediate loads, register copy
// and a load-pending scoreboard that stalls dependent reads.
// Optional macro CIRNO_REGFILE_BYPASS_EN: same-cycle writes forward into the
// operand registers (memory port first, then execute port, then stored value).
module cirno_regfile
    import cirno_pkg::*;
#(
    parameter int W     = CIRNO_W,
    parameter int NREGS = CIRNO_NREGS,
    parameter int IMM_W = CIRNO_IMM_W,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rd_en,
    input  logic             i_rx_en,
    input  logic             i_ry_en,
    input  logic [AW-1:0]    i_ra_x,
    input  logic [AW-1:0]    i_ra_y,
    input  logic             i_y_is_imm,
    input  logic [IMM_W-1:0] i_imm,
    input  wr_op_e           i_wr_op,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [AW-1:0]    i_wr_src,
    input  logic [W-1:0]     i_result,
    input  logic             i_mem_we,
    input  logic [AW-1:0]    i_mem_addr,
    input  logic [W-1:0]     i_mem_data,
    input  logic             i_ld_issue,
    input  logic [AW-1:0]    i_ld_addr,
    output logic [W-1:0]     o_x,
    output logic [W-1:0]     o_y,
    output logic             o_stall,
    output logic [NREGS-1:0] o_pending
);

    localparam int HW = W / 2;

    logic [W-1:0]  r_regs [NREGS];
    logic [W-1:0]  w_reg_next [NREGS];
    logic [W-1:0]  r_x;
    logic [W-1:0]  r_y;
    logic [W-1:0]  w_imm_ext;
    logic [HW-1:0] w_imm_half;
    logic [W-1:0]  w_copy_val;
    logic [W-1:0]  w_x_rd;
    logic [W-1:0]  w_y_rd;
    logic          w_copy_req;
    logic          w_exec_we;
    logic          w_stall;

    // Immediate as a full operand (zero-extended, or truncated if wider than W)
    generate
        if (IMM_W >= W) begin : g_imm_trunc
            assign w_imm_ext = i_imm[W-1:0];
        end else begin : g_imm_zext
            assign w_imm_ext = {{(W-IMM_W){1'b0}}, i_imm};
        end
    endgenerate

    assign w_imm_half = i_imm[HW-1:0];
    assign w_copy_val = r_regs[i_wr_src];
    assign w_copy_req = (i_wr_op == WR_COPY);

    // A stalled copy is dropped; every other execute write goes through
    assign w_exec_we = is_plain_write(i_wr_op) || (w_copy_req && !w_stall);

    cirno_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_ld_issue (i_ld_issue),
        .i_ld_addr  (i_ld_addr),
        .i_mem_we   (i_mem_we),
        .i_mem_addr (i_mem_addr),
        .i_rd_en    (i_rd_en),
        .i_rx_en    (i_rx_en),
        .i_ry_en    (i_ry_en),
        .i_ra_x     (i_ra_x),
        .i_ra_y     (i_ra_y),
        .i_copy_req (w_copy_req),
        .i_wr_src   (i_wr_src),
        .o_stall    (w_stall),
        .o_pending  (o_pending)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic         w_mem_hit;
            logic         w_exec_hit;
            logic [W-1:0] w_exec_val;

            assign w_mem_hit  = i_mem_we && (i_mem_addr == AW'(gi));
            assign w_exec_hit = w_exec_we && (i_wr_addr == AW'(gi));

            // Execute-port value; half-word loads merge with this register's other half
            always_comb begin
                w_exec_val = i_result;
                case (i_wr_op)
                    WR_HI:   w_exec_val = {w_imm_half, r_regs[gi][HW-1:0]};
                    WR_LO:   w_exec_val = {r_regs[gi][W-1:HW], w_imm_half};
                    WR_COPY: w_exec_val = w_copy_val;
                    default: w_exec_val = i_result;
                endcase
            end

            // Memory writeback outranks the execute port on the same register
            assign w_reg_next[gi] = w_mem_hit  ? i_mem_data :
                                    w_exec_hit ? w_exec_val : r_regs[gi];

            // Register storage
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_regs[gi] <= '0;
                end else begin
                    r_regs[gi] <= w_reg_next[gi];
                end
            end
        end
    endgenerate

`ifdef CIRNO_REGFILE_BYPASS_EN
    assign w_x_rd = w_reg_next[i_ra_x];
    assign w_y_rd = w_reg_next[i_ra_y];
`else
    assign w_x_rd = r_regs[i_ra_x];
    assign w_y_rd = r_regs[i_ra_y];
`endif

    // Operand capture: frozen while stalled; a Y register read outranks the immediate
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (!w_stall) begin
            if (i_rd_en && i_rx_en) begin
                r_x <= w_x_rd;
            end
            if (i_rd_en && i_ry_en) begin
                r_y <= w_y_rd;
            end else if (i_y_is_imm) begin
                r_y <= w_imm_ext;
            end
        end
    end

    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_stall = w_stall;

endmodule

// File: doc/cirno_regfile.md
# cirno_regfile

Parametrised general-purpose register file for the cirno core, the next generation of the fixed 4×8-bit register block. It provides a registered X/Y operand pair with immediate substitution, two independent write ports (execute and memory writeback), half-word immediate loads, register copy, and a load-pending scoreboard that raises `stall` when an instruction reads a register whose memory load has not returned. It sits between decode/execute and the memory stage.

## Interface
- `W`, default 8: register width; must be even.
- `NREGS`, default 4: register count; power of two, ≥2.
- `IMM_W`, default 6: immediate width; must be ≥ W/2.
- `AW`, default $clog2(NREGS): address width (derived).

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rd_en`  in  1  operand capture strobe.
- `rx_en`, `ry_en`  in  1  capture X from `ra_x` / Y from `ra_y`.
- `ra_x`, `ra_y`  in  AW  read addresses.
- `y_is_imm`  in  1  load Y from zero-extended `imm`.
- `imm`  in  IMM_W  immediate.
- `wr_op`  in  3  execute-port op, `cirno_pkg::wr_op_e`.
- `wr_addr`, `wr_src`  in  AW  destination; copy source.
- `result`  in  W  ALU result.
- `mem_we`  in  1  memory writeback valid.
- `mem_addr`  in  AW  writeback destination.
- `mem_data`  in  W  writeback data.
- `ld_issue`  in  1  load issued to `ld_addr`; mark pending.
- `ld_addr`  in  AW  load destination.
- `x`, `y`  out  W  registered operands.
- `stall`  out  1  combinational; current request blocked.
- `pending`  out  NREGS  scoreboard bits.

## Operation
- `wr_op`: WR_NONE; WR_RESULT (`result`); WR_HI (upper W/2 ← `imm[W/2-1:0]`, lower kept); WR_LO (lower W/2 ← `imm[W/2-1:0]`, upper kept); WR_COPY (← reg[`wr_src`]); reserved codes behave as WR_NONE.
- `mem_we`: reg[`mem_addr`] ← `mem_data`; clears `pending[mem_addr]`.
- Same-address conflict of `mem_we` and a non-NONE `wr_op`: memory wins, execute write dropped. Different addresses: both commit.
- Y: `y_is_imm` loads zero-extended `imm`; if `rd_en && ry_en` also asserted, register read wins.
- `ld_issue` sets `pending[ld_addr]`; coincident `mem_we` to same address still leaves it set (new load wins).
- `stall` = `rd_en` and (`rx_en` && pending[`ra_x`], or `ry_en` && pending[`ra_y`]), or `wr_op`==WR_COPY && pending[`wr_src`]. While stalled: x, y, and the COPY write hold/drop; other writes and `ld_issue` proceed.
- Pending bit cleared by `mem_we` in the same cycle does not suppress `stall` (without bypass).

## Timing
- Reset: all registers 0, `x`=`y`=0, `pending`=0; `stall` low (pending empty).
- Read latency 1 cycle: `x`/`y` valid the cycle after `rd_en`.
- Reads are read-before-write: same-cycle writes are not seen (without bypass).
- Writes visible to a read issued the following cycle.
- Reset asserted mid-operation clears everything immediately, including in-flight pending bits; late `mem_we` after reset is still applied as an ordinary write.

## Configuration
- `CIRNO_REGFILE_BYPASS_EN` defined: same-cycle forwarding into `x`/`y`, priority `mem_we` > `wr_op` > stored value (HI/LO forward the merged word); same-cycle `mem_we` to a pending read address suppresses `stall`.
- Undefined: pure read-before-write, as above.

## Structure
- `cirno_pkg`: `wr_op_e` (WR_NONE=0, WR_RESULT, WR_HI, WR_LO, WR_COPY), default W/NREGS/IMM_W constants.
- One sub-module: `cirno_scoreboard` (pending bits, set/clear priority, stall decode).

## Test plan
- Reset, then read all registers -> x=y=0, pending=0.
- W=8: WR_HI imm=0x2A to r1, next cycle WR_LO imm=0x05 to r1, read X r1 -> x=0xA5.
- `ld_issue` r2, then read Y r2 -> stall=1, y holds; `mem_we` r2 data=0x3C -> next cycle read proceeds, y=0x3C, pending=0.
- Same cycle WR_RESULT 0x11 and `mem_we` 0x22 to r3 -> r3=0x22; to r3/r0 -> r3=0x11... r0=0x22 as addressed.
- `y_is_imm` imm=0x3F with `ry_en` r0=0x07 -> y=0x07; without `ry_en` -> y=0x3F.
- Bypass defined: WR_RESULT 0x5A to r1 with same-cycle read r1 -> x=0x5A next cycle; undefined -> old value.
